// File: rtl/acc_seq_4bit.sv
// Sequential accumulator around a 4-bit add/subtract datapath: repeats acc <= acc +/- operand
// `count` times. Optional signed saturation when ACC_SAT_EN is defined.

module addsub_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       m,
    output logic [3:0] res,
    output logic       carry_out
);
    // Subtraction as a + ~b + 1, so carry_out=1 means no borrow
    logic [4:0] sum;
    assign sum       = {1'b0, a} + {1'b0, b ^ {4{m}}} + {4'b0000, m};
    assign res       = sum[3:0];
    assign carry_out = sum[4];
endmodule

module acc_seq_4bit #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             start,
    input  logic             op_sub,
    input  logic [3:0]       init,
    input  logic [3:0]       operand,
    input  logic [CNT_W-1:0] count,
    output logic [3:0]       acc,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       operand_q;
    logic             sub_q;
    logic [3:0]       res;
    logic             carry_out;
    logic             step_v;
    logic [3:0]       next_acc;

    addsub_4bit u_addsub (
        .a         (acc),
        .b         (operand_q),
        .m         (sub_q),
        .res       (res),
        .carry_out (carry_out)
    );

    assign step_v = sub_q ? ((acc[3] != operand_q[3]) && (res[3] != acc[3]))
                          : ((acc[3] == operand_q[3]) && (res[3] != acc[3]));

`ifdef ACC_SAT_EN
    assign next_acc = step_v ? (acc[3] ? 4'b1000 : 4'b0111) : res;
`else
    assign next_acc = res;
`endif

    assign zero = (acc == 4'd0);

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state     <= S_IDLE;
            cnt       <= '0;
            operand_q <= 4'd0;
            sub_q     <= 1'b0;
            acc       <= 4'd0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        operand_q <= operand;
                        sub_q     <= op_sub;
                        acc       <= init;
                        cnt       <= count;
                        carry     <= 1'b0;
                        overflow  <= 1'b0;
                        busy      <= 1'b1;
                        if (count != '0) begin
                            state <= S_RUN;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    acc      <= next_acc;
                    carry    <= carry_out;
                    overflow <= overflow | step_v;
                    cnt      <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/acc_seq_4bit.md
# acc_seq_4bit

Sequential accumulator wrapped around one `addsub_4bit` datapath instance. It supplies the adder's A/B/M operands and registers its result and carry-out. After a start request it applies the same add or subtract step `count` times (acc ← acc ± operand), which gives repeated-addition multiply and decrement loops. It then reports the final value with carry, sticky signed-overflow and zero flags, and a one-cycle done pulse.

## Interface
- `CNT_W`, default 4, width of the iteration count
- `clock`  in  1  rising-edge clock
- `reset_b`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `op_sub`  in  1  0 = add, 1 = subtract; drives adder M
- `init`  in  4  initial accumulator value
- `operand`  in  4  step operand; drives adder B
- `count`  in  CNT_W  number of steps, 0 allowed
- `acc`  out  4  accumulator; drives adder A
- `carry`  out  1  carry-out of the last executed step
- `overflow`  out  1  sticky signed (two's-complement) overflow for the current run
- `zero`  out  1  combinational `acc == 0`
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- The adder instance is fixed at 4 bits. Connections: A = `acc`, B = latched operand, M = latched op_sub.
- Carry semantics:
  - Add: carry = unsigned carry-out.
  - Subtract: carry = 1 means no borrow (A ≥ B unsigned).
- Step overflow V, computed from operand sign bits:
  - Add: V = (A[3] == B[3]) && (res[3] != A[3]).
  - Subtract: V = (A[3] != B[3]) && (res[3] != A[3]).
- FSM states and transitions:
  - IDLE, `start`=1: latch operand and op_sub, acc ← init, cnt ← count, carry ← 0, overflow ← 0. Next state is RUN if count ≠ 0, else DONE.
  - IDLE, `start`=0: stay in IDLE; all registers hold.
  - RUN, every edge: acc ← res, carry ← carry_out, overflow ← overflow | V, cnt ← cnt − 1. Go to DONE when cnt == 1, otherwise stay in RUN.
  - DONE: `done`=1 for this single cycle, then IDLE. Results hold until the next accepted start.
- `start` is ignored in RUN and DONE. Operand, op_sub and count changes during a run have no effect.
- Arithmetic wraps modulo 16 unless the saturation feature below is compiled in. The overflow flag is recorded either way.

## Timing
- Reset values: acc=0, carry=0, overflow=0, zero=1, busy=0, done=0, state=IDLE, cnt=0.
- Start accepted at edge k:
  - busy=1 from edge k.
  - acc=init immediately after edge k.
  - Steps execute at edges k+1 … k+count.
  - done=1 in the cycle after edge k+count.
  - busy=0 after edge k+count+1.
- count=0: done=1 in the cycle after edge k, with acc=init, carry=0, overflow=0.
- Back-to-back runs: a start held high through DONE is accepted at the first IDLE edge, one cycle after done.
- Reset asserted mid-run: asynchronously returns all registers to reset values. No done pulse is produced for the aborted run.
- count = 2^CNT_W − 1 must execute exactly that many steps; the count register must not wrap early.

## Configuration
- `ACC_SAT_EN` defined: on any step with V=1, acc takes the signed saturation value instead of res:
  - 4'b0111 if the true result is positive (A[3]=0).
  - 4'b1000 if it is negative.
  - carry still reflects carry_out; overflow is set.
- `ACC_SAT_EN` undefined: acc always takes res (modulo-16 wrap). Flags are identical.

## Test plan
- Wrap vs saturate: init=0, operand=3, add, count=3.
  - Without `ACC_SAT_EN`: acc=4'b1001, overflow=1, carry=0, done after 3 steps.
  - With `ACC_SAT_EN`: acc=4'b0111.
- Subtract to zero: init=2, operand=2, sub, count=1 → acc=0, zero=1, carry=1, overflow=0, done in the cycle after the first step edge.
- Borrow: init=1, operand=2, sub, count=1 → acc=4'b1111, carry=0, overflow=0, zero=0.
- count=0: init=5, start → acc=5, carry=0, overflow=0, done=1 exactly one cycle after the start edge.
- Start during RUN: init=0, operand=1, add, count=4; pulse start with operand=7 mid-run → ignored, acc=4, a single done pulse.
- Reset mid-run: reset_b low two cycles into a count=5 run → all outputs at reset values with no done pulse. After release, init=0, operand=1, add, count=2 → acc=2.
